// File: rtl/shift_sched_if.sv
// Handshake and shared-shifter signal bundle for shift_sched.
// Two requesters with valid/ready, plus the external shifter port.
interface shift_sched_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic [4:0]  req0_shamt;
  logic [4:0]  req1_shamt;
  logic        req0_ready;
  logic        req1_ready;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp0_data;
  logic [31:0] rsp1_data;
  logic        rsp0_ready;
  logic        rsp1_ready;
  logic [31:0] sh_dataA;
  logic [4:0]  sh_dataB;
  logic [5:0]  sh_signal;
  logic [31:0] sh_dataOut;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_data, req1_data,
    input  req0_shamt, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp0_data, rsp1_data,
    input  rsp0_ready, rsp1_ready,
    output sh_dataA, sh_dataB, sh_signal,
    input  sh_dataOut,
    output busy
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_data, req1_data,
    output req0_shamt, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp0_data, rsp1_data,
    output rsp0_ready, rsp1_ready,
    input  sh_dataA, sh_dataB, sh_signal,
    output sh_dataOut,
    input  busy
  );
endinterface

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one combinational shifter
// between two requesters, one operation in flight.
module shift_sched #(
  parameter logic [5:0] SRL     = 6'b000010,
  parameter logic [5:0] NOP_SIG = 6'b000000
) (
  input  logic         clk,
  input  logic         reset,
  shift_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t      state;
  logic        ptr;
  logic        owner;
  logic [31:0] op_data;
  logic [4:0]  op_shamt;
  logic [31:0] result;
  logic [5:0]  sig;
  logic        busy_q;
  logic        rv0;
  logic        rv1;
  logic        gnt0;
  logic        gnt1;
  logic        take;

  // ready is combinational, so it is also gated by reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset && state == IDLE) begin
      unique case (1'b1)
        bus.req0_valid && bus.req1_valid: begin
          gnt0 = !ptr;
          gnt1 = ptr;
        end
        bus.req0_valid && !bus.req1_valid: gnt0 = 1'b1;
        !bus.req0_valid && bus.req1_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign take = (state == RESP) &&
                (owner ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      op_data  <= '0;
      op_shamt <= '0;
      result   <= '0;
      sig      <= NOP_SIG;
      busy_q   <= 1'b0;
      rv0      <= 1'b0;
      rv1      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_data  <= gnt1 ? bus.req1_data : bus.req0_data;
            op_shamt <= gnt1 ? bus.req1_shamt : bus.req0_shamt;
            owner    <= gnt1;
            ptr      <= gnt0;
            sig      <= SRL;
            busy_q   <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          result <= bus.sh_dataOut;
          sig    <= NOP_SIG;
          rv0    <= !owner;
          rv1    <= owner;
          state  <= RESP;
        end
        RESP: begin
          if (take) begin
            rv0    <= 1'b0;
            rv1    <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rv0;
  assign bus.rsp1_valid = rv1;
  assign bus.rsp0_data  = result;
  assign bus.rsp1_data  = result;
  assign bus.sh_dataA   = op_data;
  assign bus.sh_dataB   = op_shamt;
  assign bus.sh_signal  = sig;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched with directed
// scenarios and a randomized transaction-level model.
module tb_shift_sched;

  localparam logic [5:0] SRL_C = 6'b000010;
  localparam logic [5:0] NOP_C = 6'b000000;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_chk  = 0;

  shift_sched_if bus();

  shift_sched #(
    .SRL    (SRL_C),
    .NOP_SIG(NOP_C)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // external shifter: garbage unless the function code is SRL
  always_comb begin
    bus.sh_dataOut = 32'hDEAD_BEEF;
    if (bus.sh_signal == SRL_C)
      bus.sh_dataOut = bus.sh_dataA >> bus.sh_dataB;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    bus.req0_shamt = '0;
    bus.req1_shamt = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    idle_inputs();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    o = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
         bus.rsp1_valid, bus.busy};
    n_chk++;
    if (o !== 5'b0)
      $display("FAIL rst_ctrl got %b want 00000", o);
    else n_pass++;
    n_chk++;
    if (bus.sh_signal !== NOP_C)
      $display("FAIL rst_sig got %b want %b", bus.sh_signal, NOP_C);
    else n_pass++;
    n_chk++;
    if ({bus.sh_dataA, bus.sh_dataB, bus.rsp0_data, bus.rsp1_data} !== '0)
      $display("FAIL rst_regs got %h %h %h %h want 0", bus.sh_dataA,
               bus.sh_dataB, bus.rsp0_data, bus.rsp1_data);
    else n_pass++;
    idle_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'h8000_0000;
    bus.req0_shamt = 5'd4;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b100 ||
        bus.sh_signal !== NOP_C)
      $display("FAIL single_accept got rdy=%b%b busy=%b sig=%b want 10 0 %b",
               bus.req0_ready, bus.req1_ready, bus.busy, bus.sh_signal, NOP_C);
    else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    n_chk++;
    if (bus.sh_signal !== SRL_C || bus.sh_dataA !== 32'h8000_0000 ||
        bus.sh_dataB !== 5'd4 || bus.busy !== 1'b1 || bus.rsp0_valid !== 1'b0)
      $display("FAIL single_issue got sig=%b a=%h b=%0d busy=%b rv=%b want %b 80000000 4 1 0",
               bus.sh_signal, bus.sh_dataA, bus.sh_dataB, bus.busy,
               bus.rsp0_valid, SRL_C);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 ||
        bus.rsp0_data !== 32'h0800_0000 || bus.rsp1_data !== 32'h0800_0000 ||
        bus.sh_signal !== NOP_C)
      $display("FAIL single_resp got v=%b%b d0=%h d1=%h sig=%b want 10 08000000 08000000 %b",
               bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_data, bus.rsp1_data,
               bus.sh_signal, NOP_C);
    else n_pass++;
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.rsp0_valid} !== 2'b00)
      $display("FAIL single_done got busy=%b rv=%b want 0 0",
               bus.busy, bus.rsp0_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hFFFF_FFFF;
    bus.req0_shamt = 5'd31;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h0000_00F0;
    bus.req1_shamt = 5'd4;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL rr_first got %b%b want 10", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      $display("FAIL rr_busy_rdy got %b%b want 00", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'h0000_0001)
      $display("FAIL rr_res0 got v=%b d=%h want 1 00000001",
               bus.rsp0_valid, bus.rsp0_data);
    else n_pass++;
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      $display("FAIL rr_second got %b%b want 01", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'h0000_000F)
      $display("FAIL rr_res1 got v=%b d=%h want 1 0000000f",
               bus.rsp1_valid, bus.rsp1_data);
    else n_pass++;
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      $display("FAIL rr_third got %b%b want 10", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1;
    #1;
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      $display("FAIL rr_fourth got %b%b want 01", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp;
    d = $urandom;
    s = 5'($urandom_range(1, 30));
    exp = d >> s;
    idle_inputs();
    bus.req1_valid = 1'b1;
    bus.req1_data  = d;
    bus.req1_shamt = s;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hA5A5_0000;
    bus.req0_shamt = 5'd8;
    for (int i = 0; i < 5; i++) begin
      bus.rsp1_ready = 1'b0;
      bus.rsp0_ready = i[0];
      #1;
      n_chk++;
      if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy, bus.req0_ready} !== 4'b1010 ||
          bus.rsp1_data !== exp)
        $display("FAIL bp_hold%0d got v1v0br=%b d=%h want 1010 %h", i,
                 {bus.rsp1_valid, bus.rsp0_valid, bus.busy, bus.req0_ready},
                 bus.rsp1_data, exp);
      else n_pass++;
      tick();
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.busy, bus.rsp1_valid, bus.req0_ready} !== 3'b001)
      $display("FAIL bp_release got busy/rv1/rdy0=%b want 001",
               {bus.busy, bus.rsp1_valid, bus.req0_ready});
    else n_pass++;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.rsp0_data !== 32'h00A5_A500)
      $display("FAIL bp_after got %h want 00a5a500", bus.rsp0_data);
    else n_pass++;
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_shamt0();
    idle_inputs();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 32'h1234_5678;
    bus.req1_shamt = 5'd0;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_chk++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'h1234_5678)
      $display("FAIL shamt0 got v=%b d=%h want 1 12345678",
               bus.rsp1_valid, bus.rsp1_data);
    else n_pass++;
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    #1;
    n_chk++;
    if ({bus.rsp1_valid, bus.busy} !== 2'b11 || bus.rsp1_data !== 32'h1234_5678)
      $display("FAIL wrong_owner_ready got v=%b busy=%b d=%h want 1 1 12345678",
               bus.rsp1_valid, bus.busy, bus.rsp1_data);
    else n_pass++;
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] o;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'hFFFF_0000;
      bus.req0_shamt = 5'd3;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 32'h0000_FFFF;
      bus.req1_shamt = 5'd1;
      tick();
      bus.req0_valid = 1'b0;
      if (ph == 1) tick();
      reset = 1'b0;
      #1;
      o = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
           bus.rsp1_valid, bus.busy};
      n_chk++;
      if (o !== 5'b0 || bus.sh_signal !== NOP_C ||
          bus.sh_dataA !== '0 || bus.rsp0_data !== '0)
        $display("FAIL mid_rst%0d got ctl=%b sig=%b a=%h d=%h want 0", ph,
                 o, bus.sh_signal, bus.sh_dataA, bus.rsp0_data);
      else n_pass++;
      idle_inputs();
      tick();
      reset = 1'b1;
      o = '0;
      for (int i = 0; i < 4; i++) begin
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        o = o | {2'b0, bus.rsp0_valid, bus.rsp1_valid, bus.busy};
        tick();
      end
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      n_chk++;
      if (o !== 5'b0)
        $display("FAIL mid_rst_resp%0d got %b want 00000", ph, o);
      else n_pass++;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
        $display("FAIL mid_rst_grant%0d got %b%b want 10", ph,
                 bus.req0_ready, bus.req1_ready);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_random();
    logic        pend [2];
    logic [31:0] pd   [2];
    logic [4:0]  ps   [2];
    logic        rr   [2];
    int          ptr, g, acc, own, cyc;
    logic        infl;
    logic [31:0] res;
    logic [4:0]  eo, ob;
    do_reset();
    ptr = 0;
    infl = 1'b0;
    acc = 0;
    own = 0;
    res = '0;
    for (int n = 0; n < 2; n++) pend[n] = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          pd[n] = $urandom;
          case ($urandom_range(0, 3))
            0:       ps[n] = 5'd0;
            1:       ps[n] = 5'd31;
            default: ps[n] = 5'($urandom_range(0, 31));
          endcase
        end
        rr[n] = 1'($urandom_range(0, 1));
      end
      bus.req0_valid = pend[0];
      bus.req0_data  = pd[0];
      bus.req0_shamt = ps[0];
      bus.req1_valid = pend[1];
      bus.req1_data  = pd[1];
      bus.req1_shamt = ps[1];
      bus.rsp0_ready = rr[0];
      bus.rsp1_ready = rr[1];
      #1;
      g = -1;
      if (!infl) begin
        if (pend[0] && pend[1]) g = ptr;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      eo = {g == 0, g == 1,
            infl && cyc >= acc + 2 && own == 0,
            infl && cyc >= acc + 2 && own == 1,
            infl};
      ob = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
            bus.rsp1_valid, bus.busy};
      n_chk++;
      if (ob !== eo)
        $display("FAIL rand_ctl c%0d got %b want %b", cyc, ob, eo);
      else n_pass++;
      if (eo[2] || eo[1]) begin
        n_chk++;
        if (bus.rsp0_data !== res || bus.rsp1_data !== res)
          $display("FAIL rand_data c%0d got %h %h want %h", cyc,
                   bus.rsp0_data, bus.rsp1_data, res);
        else n_pass++;
      end
      if (g >= 0) begin
        pend[g] = 1'b0;
        infl = 1'b1;
        acc = cyc;
        own = g;
        res = pd[g] >> ps[g];
        ptr = 1 - g;
      end else if (infl && cyc >= acc + 2 && rr[own]) begin
        infl = 1'b0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_shamt0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter SRL, default 6'b000010, is the shifter function code driven on sh_signal while a shift executes.
REQ-002 Parameter NOP_SIG, default 6'b000000, is the shifter function code driven when no shift executes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 req0_data / req1_data  input  32  operand to shift.
REQ-007 req0_shamt / req1_shamt  input  5  shift amount, 0..31.
REQ-008 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-009 rsp0_valid / rsp1_valid  output  1  result for requester n available.
REQ-010 rsp0_data / rsp1_data  output  32  logical-right-shift result.
REQ-011 rsp0_ready / rsp1_ready  input  1  requester n takes the result.
REQ-012 sh_dataA  output  32  operand to shared shifter.
REQ-013 sh_dataB  output  5  shift amount to shared shifter.
REQ-014 sh_signal  output  6  function code to shared shifter.
REQ-015 sh_dataOut  input  32  combinational result from shared shifter.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 Block SHALL share one combinational shifter between two requesters, one operation in flight.
REQ-018 FSM states: IDLE, ISSUE, RESP; encoding free.
REQ-019 IDLE: if any req_n_valid, grant one, assert its req_n_ready combinationally same cycle, register data/shamt/owner, go ISSUE.
REQ-020 req_n_ready SHALL be high only in IDLE, only for the granted requester, and never for both in one cycle.
REQ-021 Arbitration: round-robin; pointer initial value requester 0; both valid -> grant pointer; one valid -> grant it regardless of pointer.
REQ-022 Pointer SHALL update only on a grant, to the requester not granted.
REQ-023 ISSUE (one cycle): sh_dataA/sh_dataB = registered operands, sh_signal = SRL; on exit register sh_dataOut into result register; go RESP.
REQ-024 Outside ISSUE: sh_signal = NOP_SIG; sh_dataA, sh_dataB hold last registered operands.
REQ-025 RESP: rsp_n_valid high for owner only, rsp_n_data = result register; other rsp_valid low.
REQ-026 RESP holds, result stable, until owner's rsp_n_ready = 1; then IDLE next cycle.
REQ-027 rsp_n_ready from non-owner, and in IDLE/ISSUE, SHALL be ignored.
REQ-028 rsp_n_data for both n SHALL equal result register at all times (validity given only by rsp_n_valid).
REQ-029 Latency: acceptance edge at cycle N -> rsp_valid high during cycle N+2; min issue interval 3 cycles.
REQ-030 Requests arriving outside IDLE SHALL not be accepted; requester holds valid/operands until ready.
REQ-031 shamt = 0 -> result equals operand; shamt = 31 -> result = {31'b0, data[31]}.
REQ-032 Result width 32; no sign extension (logical shift only).

Reset
REQ-033 reset = 0 SHALL force, asynchronously: state IDLE, pointer requester 0, operand/result/owner registers 0, sh_signal NOP_SIG, all ready/valid and busy 0.
REQ-034 reset asserted in ISSUE or RESP SHALL discard the in-flight operation; no response after release.
REQ-035 First grant possible on first rising edge with reset = 1.

Verification
REQ-036 Single req0: data 0x8000_0000, shamt 4, accepted cycle N -> rsp0_valid cycle N+2, rsp0_data 0x0800_0000, sh_signal SRL only in cycle N+1.
REQ-037 Both valid from reset, req0 0xFFFF_FFFF shamt 31, req1 0x0000_00F0 shamt 4 -> req0 granted first, result 0x0000_0001; then req1, result 0x0000_000F; pointer alternates on repeat.
REQ-038 Backpressure: rsp1_ready low 5 cycles in RESP -> rsp1_valid/data stable, busy high, req0 not accepted; release -> IDLE next cycle.
REQ-039 shamt 0 with data 0x1234_5678 -> result 0x1234_5678; rsp0_ready pulsed in RESP for req1-owned op -> ignored.
REQ-040 reset low mid-ISSUE and mid-RESP -> all outputs zero immediately, no response after release, next grant goes to requester 0.
